cnn_job_scheduler: RTL and testbench

CNN_JOB_SCHEDULER -- requirements
Module: cnn_job_scheduler

---
 rtl/cnn_job_scheduler_pkg.sv | 13 +
 rtl/cnn_job_scheduler_rr_arbiter.sv | 29 ++
 rtl/cnn_job_scheduler.sv | 103 ++++++++++
 tb/tb_cnn_job_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_job_scheduler_pkg.sv
// Shared npu package: scheduler FSM state encoding and default watchdog limit.
package cnn_job_scheduler_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
    localparam int WATCHDOG_W             = 32;

endpackage

// File: rtl/cnn_job_scheduler_rr_arbiter.sv
// Round-robin winner selection: the search starts one past the previous grant.
module rr_arbiter
    import cnn_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any,
    output logic [IDX_W-1:0]   winner_idx
);

    logic [IDX_W-1:0] cand;

    // Walk the candidates from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        any        = |req;
        winner_idx = '0;
        cand       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (req[cand]) begin
                winner_idx = cand;
            end
        end
    end

endmodule

// File: rtl/cnn_job_scheduler.sv
// Shares one CNN engine among NUM_REQ requesters with round-robin arbitration
// and a per-job watchdog that aborts and flushes a stuck engine.
module cnn_job_scheduler
    import cnn_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_pool_type,
    input  logic [2*NUM_REQ-1:0] req_act_type,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy,
    output logic                 eng_start,
    output logic                 eng_pool_type,
    output logic [1:0]           eng_act_type,
    output logic                 eng_flush,
    input  logic                 eng_input_taken,
    input  logic                 eng_valid_out,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic                 resp_timeout
);

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [IDX_W-1:0]      last_grant;
    logic [WATCHDOG_W-1:0] watchdog;
    logic                  arb_any;
    logic [IDX_W-1:0]      arb_winner;
    logic                  wd_expired;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (arb_any),
        .winner_idx (arb_winner)
    );

    assign wd_expired = (watchdog == WATCHDOG_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic; a completion in the expiry cycle takes priority over the flush.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (arb_any) state_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (eng_input_taken && eng_valid_out) state_next = ST_DONE;
                else if (wd_expired)                  state_next = ST_FLUSH;
                else if (eng_input_taken)             state_next = ST_RUN;
            end
            ST_RUN: begin
                if (eng_valid_out)   state_next = ST_DONE;
                else if (wd_expired) state_next = ST_FLUSH;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, watchdog and job configuration; configuration is captured only at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            last_grant    <= IDX_W'(NUM_REQ - 1);
            watchdog      <= '0;
            grant_idx     <= '0;
            eng_pool_type <= 1'b0;
            eng_act_type  <= 2'b00;
            req_ready     <= '0;
        end else begin
            state     <= state_next;
            req_ready <= '0;
            if (state == ST_IDLE && arb_any) begin
                grant_idx     <= arb_winner;
                last_grant    <= arb_winner;
                eng_pool_type <= req_pool_type[arb_winner];
                eng_act_type  <= req_act_type[{arb_winner, 1'b0} +: 2];
                watchdog      <= '0;
                req_ready     <= NUM_REQ'(1) << arb_winner;
            end else if (state == ST_LAUNCH || state == ST_RUN) begin
                watchdog <= watchdog + 1'b1;
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign eng_start    = (state == ST_LAUNCH);
    assign eng_flush    = (state == ST_FLUSH);
    assign resp_timeout = (state == ST_FLUSH);
    assign resp_valid   = (state == ST_DONE || state == ST_FLUSH) ?
                          (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: tb/tb_cnn_job_scheduler.sv
// Directed bench for cnn_job_scheduler: instance A uses the default watchdog,
// instance B uses a 16-cycle watchdog for the abort scenarios.
module tb_cnn_job_scheduler;

    logic       clk;
    logic       rst;

    logic [3:0] a_req_valid, a_pool, a_resp, a_ready;
    logic [7:0] a_act;
    logic       a_taken, a_vout, a_busy, a_start, a_pool_o, a_flush, a_tmo;
    logic [1:0] a_grant, a_act_o;

    logic [3:0] b_req_valid, b_pool, b_resp, b_ready;
    logic [7:0] b_act;
    logic       b_taken, b_vout, b_busy, b_start, b_pool_o, b_flush, b_tmo;
    logic [1:0] b_grant, b_act_o;

    int assert_count;
    int fail_count;

    cnn_job_scheduler dut_a (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (a_req_valid),
        .req_pool_type   (a_pool),
        .req_act_type    (a_act),
        .req_ready       (a_ready),
        .grant_idx       (a_grant),
        .busy            (a_busy),
        .eng_start       (a_start),
        .eng_pool_type   (a_pool_o),
        .eng_act_type    (a_act_o),
        .eng_flush       (a_flush),
        .eng_input_taken (a_taken),
        .eng_valid_out   (a_vout),
        .resp_valid      (a_resp),
        .resp_timeout    (a_tmo)
    );

    cnn_job_scheduler #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut_b (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (b_req_valid),
        .req_pool_type   (b_pool),
        .req_act_type    (b_act),
        .req_ready       (b_ready),
        .grant_idx       (b_grant),
        .busy            (b_busy),
        .eng_start       (b_start),
        .eng_pool_type   (b_pool_o),
        .eng_act_type    (b_act_o),
        .eng_flush       (b_flush),
        .eng_input_taken (b_taken),
        .eng_valid_out   (b_vout),
        .resp_valid      (b_resp),
        .resp_timeout    (b_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] pool, input logic [7:0] act,
                                 input logic taken, input logic vout);
        a_req_valid = req;
        a_pool      = pool;
        a_act       = act;
        a_taken     = taken;
        a_vout      = vout;
    endtask

    task automatic waitReadyA();
        for (int w = 0; w < 8 && a_ready == 4'b0000; w++) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
        b_req_valid = '0; b_pool = '0; b_act = '0; b_taken = 1'b0; b_vout = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_ready",   32'(a_ready),  0);
        checkOutput("rst_resp",    32'(a_resp),   0);
        checkOutput("rst_tmo",     32'(a_tmo),    0);
        checkOutput("rst_start",   32'(a_start),  0);
        checkOutput("rst_flush",   32'(a_flush),  0);
        checkOutput("rst_busy",    32'(a_busy),   0);
        checkOutput("rst_grant",   32'(a_grant),  0);
        checkOutput("rst_pool",    32'(a_pool_o), 0);
        checkOutput("rst_act",     32'(a_act_o),  0);
        rst = 1'b0;

        // Single request: input_taken 5 cycles after start, valid_out 20 later
        applyStimulus(4'b0001, 4'b0001, 8'b0000_0010, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1_ready",  32'(a_ready),  32'h1);
        checkOutput("t1_start",  32'(a_start),  1);
        checkOutput("t1_grant",  32'(a_grant),  0);
        checkOutput("t1_pool",   32'(a_pool_o), 1);
        checkOutput("t1_act",    32'(a_act_o),  2);
        checkOutput("t1_busy",   32'(a_busy),   1);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            checkOutput("t1_start_hold", 32'(a_start), 1);
            checkOutput("t1_ready_once", 32'(a_ready), 0);
            if (c == 6) a_taken = 1'b1;
        end
        @(negedge clk);
        a_taken = 1'b0;
        checkOutput("t1_start_off", 32'(a_start), 0);
        checkOutput("t1_run_busy",  32'(a_busy),  1);
        for (int c = 8; c <= 26; c++) begin
            @(negedge clk);
            checkOutput("t1_no_early_resp", 32'(a_resp), 0);
            if (c == 26) a_vout = 1'b1;
        end
        @(negedge clk);
        a_vout = 1'b0;
        checkOutput("t1_resp",      32'(a_resp),   32'h1);
        checkOutput("t1_resp_tmo",  32'(a_tmo),    0);
        checkOutput("t1_latched_p", 32'(a_pool_o), 1);
        checkOutput("t1_latched_a", 32'(a_act_o),  2);
        @(negedge clk);
        checkOutput("t1_resp_once", 32'(a_resp),   0);
        checkOutput("t1_idle",      32'(a_busy),   0);
        checkOutput("t1_hold_pool", 32'(a_pool_o), 1);
        checkOutput("t1_hold_act",  32'(a_act_o),  2);

        // Spurious engine pulses while idle
        a_vout = 1'b1; a_taken = 1'b1;
        @(negedge clk);
        a_vout = 1'b0; a_taken = 1'b0;
        checkOutput("spur_resp",  32'(a_resp),  0);
        checkOutput("spur_busy",  32'(a_busy),  0);
        checkOutput("spur_start", 32'(a_start), 0);

        // Fairness: all four requesting, eight jobs, each finishing in LAUNCH
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b1010, 8'b11_10_01_00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            waitReadyA();
            checkOutput("rr_grant", 32'(a_grant),  32'(j % 4));
            checkOutput("rr_ready", 32'(a_ready),  32'(1 << (j % 4)));
            checkOutput("rr_pool",  32'(a_pool_o), 32'((j % 4) & 1));
            checkOutput("rr_act",   32'(a_act_o),  32'(j % 4));
            a_taken = 1'b1; a_vout = 1'b1;
            @(negedge clk);
            a_taken = 1'b0; a_vout = 1'b0;
            checkOutput("rr_done_resp", 32'(a_resp), 32'(1 << (j % 4)));
            checkOutput("rr_done_tmo",  32'(a_tmo),  0);
            @(negedge clk);
        end
        a_req_valid = 4'b0000;

        // Mid-job reset, then requester 3 wins first
        a_req_valid = 4'b0100;
        waitReadyA();
        checkOutput("mr_grant", 32'(a_grant), 2);
        a_req_valid = 4'b0000;
        a_taken = 1'b1;
        @(negedge clk);
        a_taken = 1'b0;
        checkOutput("mr_run_busy", 32'(a_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        a_req_valid = 4'b1000;
        @(negedge clk);
        checkOutput("mr_ready", 32'(a_ready),  0);
        checkOutput("mr_resp",  32'(a_resp),   0);
        checkOutput("mr_tmo",   32'(a_tmo),    0);
        checkOutput("mr_start", 32'(a_start),  0);
        checkOutput("mr_flush", 32'(a_flush),  0);
        checkOutput("mr_busy",  32'(a_busy),   0);
        checkOutput("mr_grant0",32'(a_grant),  0);
        checkOutput("mr_act0",  32'(a_act_o),  0);
        rst = 1'b0;
        waitReadyA();
        checkOutput("mr_grant3", 32'(a_grant), 3);
        checkOutput("mr_ready3", 32'(a_ready), 32'h8);
        a_req_valid = 4'b0000;
        a_taken = 1'b1; a_vout = 1'b1;
        @(negedge clk);
        a_taken = 1'b0; a_vout = 1'b0;
        checkOutput("mr_resp3", 32'(a_resp), 32'h8);
        @(negedge clk);

        // Timeout on instance B: engine takes inputs but never completes
        b_req_valid = 4'b0010;
        @(negedge clk);
        checkOutput("to_ready", 32'(b_ready), 32'h2);
        checkOutput("to_grant", 32'(b_grant), 1);
        b_req_valid = 4'b0000;
        b_taken = 1'b1;
        @(negedge clk);
        b_taken = 1'b0;
        for (int c = 3; c <= 16; c++) begin
            @(negedge clk);
            checkOutput("to_no_flush", 32'(b_flush), 0);
            checkOutput("to_no_resp",  32'(b_resp),  0);
        end
        @(negedge clk);
        checkOutput("to_flush",     32'(b_flush), 1);
        checkOutput("to_resp",      32'(b_resp),  32'h2);
        checkOutput("to_tmo",       32'(b_tmo),   1);
        checkOutput("to_start_off", 32'(b_start), 0);
        @(negedge clk);
        checkOutput("to_flush_once", 32'(b_flush), 0);
        checkOutput("to_resp_once",  32'(b_resp),  0);
        checkOutput("to_tmo_once",   32'(b_tmo),   0);
        checkOutput("to_idle",       32'(b_busy),  0);

        // Next job on B is accepted normally
        b_req_valid = 4'b0100;
        @(negedge clk);
        checkOutput("to_next_ready", 32'(b_ready), 32'h4);
        checkOutput("to_next_grant", 32'(b_grant), 2);
        b_req_valid = 4'b0000;
        b_taken = 1'b1; b_vout = 1'b1;
        @(negedge clk);
        b_taken = 1'b0; b_vout = 1'b0;
        checkOutput("to_next_resp", 32'(b_resp), 32'h4);
        checkOutput("to_next_tmo",  32'(b_tmo),  0);
        @(negedge clk);

        // Completion arriving in the expiry cycle wins over the flush
        b_req_valid = 4'b0001;
        @(negedge clk);
        checkOutput("race_grant", 32'(b_grant), 0);
        b_req_valid = 4'b0000;
        b_taken = 1'b1;
        @(negedge clk);
        b_taken = 1'b0;
        for (int c = 3; c <= 16; c++) begin
            @(negedge clk);
            if (c == 16) b_vout = 1'b1;
        end
        @(negedge clk);
        b_vout = 1'b0;
        checkOutput("race_resp",  32'(b_resp),  32'h1);
        checkOutput("race_tmo",   32'(b_tmo),   0);
        checkOutput("race_flush", 32'(b_flush), 0);
        @(negedge clk);
        checkOutput("race_idle", 32'(b_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
